// File: rtl/button_conditioner_pkg.sv
//==============================================================================
// Module   : btn_cond_pkg
// Purpose  : Shared state encoding and helpers for the push-button conditioner.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package btn_cond_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        HELD        = 3'd2,
        LONG        = 3'd3,
        DEB_RELEASE = 3'd4
    } btn_state_t;

    // Counter width able to hold n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/button_conditioner_sync_2ff.sv
//==============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchroniser with synchronous reset to a chosen level.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
//==============================================================================
// Module   : button_conditioner
// Purpose  : Synchronise and debounce a push-button pad; emit level plus
//            press / release / long-press / auto-repeat one-cycle pulses.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 240_000,
    parameter int LONG_CYC     = 24_000_000,
    parameter int REPEAT_CYC   = 4_800_000,
    parameter bit ACTIVE_HIGH  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int c_DEB_W  = cnt_width(DEBOUNCE_CYC);
    localparam int c_HOLD_W = cnt_width(LONG_CYC);
    localparam int c_REP_W  = cnt_width(REPEAT_CYC);

    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(LONG_CYC - 1);
    localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REPEAT_CYC - 1);

    // Synchroniser resets to the released pad level so no phantom press appears.
    localparam logic c_PAD_IDLE = ACTIVE_HIGH ? 1'b0 : 1'b1;

    logic w_sync_out;
    logic w_btn_s;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (c_PAD_IDLE)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (w_sync_out)
    );

    assign w_btn_s = ACTIVE_HIGH ? w_sync_out : ~w_sync_out;

    btn_state_t          r_state,    w_state_nxt;
    logic [c_DEB_W-1:0]  r_deb_cnt,  w_deb_nxt;
    logic [c_HOLD_W-1:0] r_hold_cnt, w_hold_nxt;
    logic [c_REP_W-1:0]  r_rep_cnt,  w_rep_nxt;
    logic                r_was_long, w_was_long_nxt;
    logic                r_level,    w_level_nxt;
    logic                r_press,    w_press_nxt;
    logic                r_release,  w_release_nxt;
    logic                r_long,     w_long_nxt;
    logic                r_repeat,   w_repeat_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            r_rep_cnt  <= '0;
            r_was_long <= 1'b0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_deb_cnt  <= w_deb_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rep_cnt  <= w_rep_nxt;
            r_was_long <= w_was_long_nxt;
            r_level    <= w_level_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_long     <= w_long_nxt;
            r_repeat   <= w_repeat_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_deb_nxt      = r_deb_cnt;
        w_hold_nxt     = r_hold_cnt;
        w_rep_nxt      = r_rep_cnt;
        w_was_long_nxt = r_was_long;
        w_level_nxt    = r_level;
        w_press_nxt    = 1'b0;
        w_release_nxt  = 1'b0;
        w_long_nxt     = 1'b0;
        w_repeat_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_nxt = DEB_PRESS;
                    w_deb_nxt   = '0;
                end
            end

            DEB_PRESS: begin
                if (!w_btn_s) begin
                    w_state_nxt = IDLE;
                end else if (r_deb_cnt == c_DEB_LAST) begin
                    w_state_nxt = HELD;
                    w_press_nxt = 1'b1;
                    w_level_nxt = 1'b1;
                    w_hold_nxt  = '0;
                end else begin
                    w_deb_nxt = r_deb_cnt + 1'b1;
                end
            end

            HELD: begin
                if (!w_btn_s) begin
                    w_state_nxt    = DEB_RELEASE;
                    w_deb_nxt      = '0;
                    w_was_long_nxt = 1'b0;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = LONG;
                    w_long_nxt  = 1'b1;
                    w_rep_nxt   = '0;
                end else begin
                    w_hold_nxt = r_hold_cnt + 1'b1;
                end
            end

            LONG: begin
                if (!w_btn_s) begin
                    w_state_nxt    = DEB_RELEASE;
                    w_deb_nxt      = '0;
                    w_was_long_nxt = 1'b1;
                end else if (r_rep_cnt == c_REP_LAST) begin
                    w_repeat_nxt = 1'b1;
                    w_rep_nxt    = '0;
                end else begin
                    w_rep_nxt = r_rep_cnt + 1'b1;
                end
            end

            // Hold and repeat counters stay frozen so a bounce resumes where it left off.
            DEB_RELEASE: begin
                if (w_btn_s) begin
                    w_state_nxt = r_was_long ? LONG : HELD;
                end else if (r_deb_cnt == c_DEB_LAST) begin
                    w_state_nxt   = IDLE;
                    w_release_nxt = 1'b1;
                    w_level_nxt   = 1'b0;
                end else begin
                    w_deb_nxt = r_deb_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign long_pulse    = r_long;
    assign repeat_pulse  = r_repeat;

endmodule

`default_nettype wire
